// File: rtl/seq_wide_comparator.sv
// ---------------------------------------------------------------------------
// seq_wide_comparator
//   Multi-cycle magnitude comparator for W = N*WORDS bit operands. Operands,
//   mode and cascade inputs are latched on an accepted start. The comparator
//   then examines one N-bit chunk per cycle, MSB chunk first, and stops at
//   the first chunk that differs. If every chunk matches, the latched cascade
//   inputs from the lower-order stage are passed through as the result.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        request; accepted only while idle (busy=0)
//   signed_mode  1 = two's-complement operands, 0 = unsigned
//   Iagtb/Iaeqb/Ialtb  cascade inputs from the lower-order stage
//   a, b         W-bit operands
//   busy         high from the cycle after an accepted start until done
//   done         one-cycle pulse, result valid
//   Oagtb/Oaeqb/Oaltb  registered result, held until next result or reset
//   chunks_used  number of chunks examined for the last result
// ---------------------------------------------------------------------------
module seq_wide_comparator #(
  parameter  int N     = 4,
  parameter  int WORDS = 4,
  localparam int W     = N * WORDS,
  localparam int CW    = $clog2(WORDS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          signed_mode,
  input  logic          Iagtb,
  input  logic          Iaeqb,
  input  logic          Ialtb,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          busy,
  output logic          done,
  output logic          Oagtb,
  output logic          Oaeqb,
  output logic          Oaltb,
  output logic [CW-1:0] chunks_used
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  // Inverting the sign bit maps two's-complement ordering onto unsigned
  // ordering, so one unsigned comparator serves both modes.
  localparam logic [N-1:0] SIGN_MASK = N'(1) << (N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_signed;
  logic          r_cgt;
  logic          r_ceq;
  logic          r_clt;
  logic [IW-1:0] r_idx;
  logic          r_gt;
  logic          r_eq;
  logic          r_lt;
  logic [CW-1:0] r_chunks;

  logic [N-1:0]  w_chunks_a [WORDS];
  logic [N-1:0]  w_chunks_b [WORDS];
  logic [N-1:0]  w_key_a;
  logic [N-1:0]  w_key_b;
  logic          w_flip;
  logic          w_ne;
  logic          w_gt;
  logic          w_last;

  // Split the latched operands into chunk arrays for the per-cycle mux.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_chunk
      assign w_chunks_a[gi] = r_a[gi*N +: N];
      assign w_chunks_b[gi] = r_b[gi*N +: N];
    end
  endgenerate

  // Only the MSB chunk carries the sign; lower chunks are magnitude bits.
  assign w_flip  = r_signed && (r_idx == IW'(WORDS - 1));
  assign w_key_a = w_chunks_a[r_idx] ^ (w_flip ? SIGN_MASK : '0);
  assign w_key_b = w_chunks_b[r_idx] ^ (w_flip ? SIGN_MASK : '0);
  assign w_ne    = (w_key_a != w_key_b);
  assign w_gt    = (w_key_a > w_key_b);
  assign w_last  = (r_idx == '0);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = CMP;
      CMP:     if (w_ne || w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: operand latches, chunk index and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_cgt    <= 1'b0;
      r_ceq    <= 1'b0;
      r_clt    <= 1'b0;
      r_idx    <= '0;
      r_gt     <= 1'b0;
      r_eq     <= 1'b0;
      r_lt     <= 1'b0;
      r_chunks <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_signed <= signed_mode;
            r_cgt    <= Iagtb;
            r_ceq    <= Iaeqb;
            r_clt    <= Ialtb;
            r_idx    <= IW'(WORDS - 1);
          end
        end
        CMP: begin
          if (w_ne) begin
            r_gt     <= w_gt;
            r_lt     <= !w_gt;
            r_eq     <= 1'b0;
            r_chunks <= CW'(WORDS) - CW'(r_idx);
          end else if (w_last) begin
            // All chunks equal: the lower-order stage decides, verbatim.
            r_gt     <= r_cgt;
            r_eq     <= r_ceq;
            r_lt     <= r_clt;
            r_chunks <= CW'(WORDS);
          end else begin
            r_idx    <= r_idx - IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign Oagtb       = r_gt;
  assign Oaeqb       = r_eq;
  assign Oaltb       = r_lt;
  assign chunks_used = r_chunks;

endmodule

// File: tb/tb_seq_wide_comparator.sv
// ---------------------------------------------------------------------------
// tb_seq_wide_comparator
//   Directed bench for seq_wide_comparator with N=4, WORDS=4 (16-bit
//   operands). Expected results are hand-computed per vector.
// ---------------------------------------------------------------------------
module tb_seq_wide_comparator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        signed_mode;
  logic        Iagtb;
  logic        Iaeqb;
  logic        Ialtb;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic        Oagtb;
  logic        Oaeqb;
  logic        Oaltb;
  logic [2:0]  chunks_used;

  int total = 0;
  int bad   = 0;

  seq_wide_comparator #(.N(4), .WORDS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .Iagtb       (Iagtb),
    .Iaeqb       (Iaeqb),
    .Ialtb       (Ialtb),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .Oagtb       (Oagtb),
    .Oaeqb       (Oaeqb),
    .Oaltb       (Oaltb),
    .chunks_used (chunks_used)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one compare from an idle cycle (called #1 after a rising edge).
  // Operand/mode/cascade inputs are scrambled while busy to prove latching.
  // If poke > 0, a conflicting start is pulsed at that point of the wait.
  task automatic run_cmp(input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tsm, input logic tg, input logic te,
                         input logic tl, input logic xg, input logic xe,
                         input logic xl, input int xk, input int poke,
                         input string tag);
    int lat;
    a = ta; b = tb_v; signed_mode = tsm;
    Iagtb = tg; Iaeqb = te; Ialtb = tl;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    signed_mode = ~tsm; Iagtb = ~tg; Iaeqb = ~te; Ialtb = ~tl;
    chk(32'(busy), 32'd1, {tag, " busy_after_start"});
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      if (lat == poke) begin
        a = 16'hFFFF; b = 16'h0000; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    $display("txn %s: a=%h b=%h sm=%0d lat=%0d gt=%0d eq=%0d lt=%0d chunks=%0d",
             tag, ta, tb_v, tsm, lat, Oagtb, Oaeqb, Oaltb, chunks_used);
    chk(32'(lat), 32'(xk + 1), {tag, " latency"});
    chk(32'(Oagtb), 32'(xg), {tag, " Oagtb"});
    chk(32'(Oaeqb), 32'(xe), {tag, " Oaeqb"});
    chk(32'(Oaltb), 32'(xl), {tag, " Oaltb"});
    chk(32'(chunks_used), 32'(xk), {tag, " chunks_used"});
    chk(32'(busy), 32'd1, {tag, " busy_in_done"});
    @(posedge clk); #1;
    chk(32'(done), 32'd0, {tag, " done_one_cycle"});
    chk(32'(busy), 32'd0, {tag, " busy_after_done"});
    chk(32'({Oagtb, Oaeqb, Oaltb}), 32'({xg, xe, xl}), {tag, " result_hold"});
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0;
    Iagtb = 1'b0; Iaeqb = 1'b0; Ialtb = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk(32'(busy), 32'd0, "reset busy");
    chk(32'(done), 32'd0, "reset done");
    chk(32'({Oagtb, Oaeqb, Oaltb}), 32'd0, "reset results");
    chk(32'(chunks_used), 32'd0, "reset chunks_used");
    rst_n = 1'b1;

    // Each call starts in the idle cycle right after the previous done,
    // so back-to-back acceptance is exercised throughout.
    //        a         b         sm    cascade           expected       k
    run_cmp(16'hA000, 16'h9FFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, "u_msb_gt");
    run_cmp(16'h1234, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4, 0, "u_lsb_lt");
    run_cmp(16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4, 0, "eq_casc_eq");
    run_cmp(16'hBEEF, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4, 0, "eq_casc_gt");
    run_cmp(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, "s_neg_lt");
    run_cmp(16'h8000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, "u_same_gt");
    // Signed mode, MSB chunks equal: chunk 2 (F vs 7) compares unsigned.
    run_cmp(16'h0F00, 16'h0700, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0, "s_low_unsigned");
    // Signed, both negative: -1 > -32768.
    run_cmp(16'hFFFF, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, "s_both_neg");
    // Unsigned, third chunk decides: 0x5 < 0x9.
    run_cmp(16'h3350, 16'h3390, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 0, "u_chunk1_lt");
    // Illegal cascade combinations pass straight through when equal.
    run_cmp(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4, 0, "casc_all1");
    run_cmp(16'h7777, 16'h7777, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 0, "casc_all0");
    // A start pulse with new operands while busy must be ignored.
    run_cmp(16'h1234, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4, 2, "busy_ignore");

    // Reset in the middle of a 4-chunk compare.
    a = 16'h1234; b = 16'h1235; signed_mode = 1'b0;
    Iagtb = 1'b0; Iaeqb = 1'b0; Ialtb = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    $display("txn mid_reset: busy=%0d done=%0d gt=%0d eq=%0d lt=%0d chunks=%0d",
             busy, done, Oagtb, Oaeqb, Oaltb, chunks_used);
    chk(32'(busy), 32'd0, "mid_reset busy");
    chk(32'(done), 32'd0, "mid_reset done");
    chk(32'({Oagtb, Oaeqb, Oaltb}), 32'd0, "mid_reset results");
    chk(32'(chunks_used), 32'd0, "mid_reset chunks_used");
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1;
    end
    chk(32'(seen), 32'd0, "mid_reset no_done");

    // Recovery after reset.
    run_cmp(16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_wide_comparator.md
Name: seq_wide_comparator

Overview:
- Multi-cycle magnitude comparator for wide operands (N*WORDS bits).
- Operands are latched on start and compared one N-bit chunk per cycle, MSB chunk first.
- Comparison terminates early at the first unequal chunk.
- Supports unsigned and two's-complement signed modes, and keeps the cascade-input semantics (Iagtb/Iaeqb/Ialtb) of the team's combinational comparators so results can chain with lower-order stages.

Parameters:
- N, 4, chunk width in bits compared per cycle (>=1)
- WORDS, 4, number of chunks; total operand width W = N*WORDS (>=1)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only when busy=0
- signed_mode  input  1  1 = operands are two's complement W-bit, 0 = unsigned; latched on start
- Iagtb  input  1  cascade greater-than from lower-order stage; latched on start
- Iaeqb  input  1  cascade equal from lower-order stage; latched on start
- Ialtb  input  1  cascade less-than from lower-order stage; latched on start
- a  input  W  operand A; latched on start
- b  input  W  operand B; latched on start
- busy  output  1  high from cycle after accepted start until done cycle inclusive
- done  output  1  one-cycle pulse, result valid
- Oagtb  output  1  registered result A>B
- Oaeqb  output  1  registered result A==B
- Oaltb  output  1  registered result A<B
- chunks_used  output  clog2(WORDS+1)  number of chunks examined for the last result (1..WORDS)

Behaviour:
- Reset (rst_n=0 at rising edge): state=IDLE; busy, done, Oagtb, Oaeqb and Oaltb are 0; chunks_used=0; internal index and latches are cleared. Reset mid-operation aborts the comparison with no done pulse.
- FSM has three states: IDLE, CMP and DONE.
- IDLE: if start=1, latch a, b, signed_mode and cascade inputs, set idx=WORDS-1, and go to CMP. busy=1 from the next cycle.
- CMP, one chunk per cycle, chunk idx = bits [idx*N+N-1 : idx*N]:
  - Chunk idx=WORDS-1 with signed_mode=1 is compared as signed N-bit. All other chunks, and all chunks in unsigned mode, are compared unsigned.
  - Chunks unequal: register gt/lt from the chunk compare, set Oaeqb=0, set chunks_used=WORDS-idx, and go to DONE.
  - Chunks equal and idx==0: register Oagtb=Iagtb, Oaeqb=Iaeqb and Oaltb=Ialtb from the latched cascade inputs, set chunks_used=WORDS, and go to DONE.
  - Chunks equal and idx>0: idx decrements and the FSM stays in CMP.
- DONE: done=1 and busy=1 for exactly one cycle, then go to IDLE. Outputs update on the edge entering DONE and hold until the next result or reset.
- Latency: start sampled at edge t; done is high during cycle t+k+1, where k=chunks_used.
  - Minimum latency is 2 cycles (MSB chunk differs).
  - Maximum latency is WORDS+1 cycles.
- Back-to-back: start sampled in the IDLE cycle following DONE is accepted. start while busy=1 is ignored, with no queuing.
- Operand and mode inputs are don't-care while busy (latched copies are used).
- Cascade inputs are passed through unvalidated. Illegal combinations, e.g. all 1 or all 0, propagate verbatim when A==B, matching the combinational comparator semantics.
- WORDS=1: a single CMP cycle, with the signed rule applied to that chunk.

Test Plan:
- Unsigned, N=4, WORDS=4: a=16'hA000, b=16'h9FFF, start -> done 2 cycles later, Oagtb=1, Oaeqb=0, Oaltb=0, chunks_used=1.
- Unsigned: a=16'h1234, b=16'h1235 -> done after 4 chunks (5 cycles), Oaltb=1, chunks_used=4.
- Equal with cascade: a=b=16'hBEEF, Iagtb=0, Iaeqb=1, Ialtb=0 -> Oaeqb=1, chunks_used=4. Repeat with Iagtb=1, Iaeqb=0 -> Oagtb=1, Oaeqb=0.
- Signed: a=16'h8000 (-32768), b=16'h0001, signed_mode=1 -> Oaltb=1, chunks_used=1. Same operands with signed_mode=0 -> Oagtb=1.
- Protocol: while busy, pulse start with new operands -> ignored, first result unchanged. start in the cycle after done -> accepted. done is exactly 1 cycle wide.
- Reset: assert rst_n=0 during CMP of a 4-chunk compare -> next cycle busy=0, done=0, all O*=0, chunks_used=0, and no done pulse afterward.
